// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the 5-stage pipeline and its hazard/stall controller.
// The pipeline side drives hazard information; the controller returns register controls.
interface hazard_stall_controller_if #(
    parameter int STALL_CNT_WIDTH = 16
);
    logic [4:0]                 ifIdRs;
    logic [4:0]                 ifIdRt;
    logic                       ifIdUsesRt;
    logic                       idExMemRead;
    logic [4:0]                 idExRt;
    logic                       mulStart;
    logic                       branchTaken;
    logic                       pcWrite;
    logic                       ifIdWrite;
    logic                       ifIdFlush;
    logic                       idExWrite;
    logic                       idExBubble;
    logic                       exMemBubble;
    logic                       mulCapture;
    logic [1:0]                 state;
    logic [STALL_CNT_WIDTH-1:0] stallCycles;

    modport master (
        output ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt, mulStart, branchTaken,
        input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble,
               mulCapture, state, stallCycles
    );

    modport slave (
        input  ifIdRs, ifIdRt, ifIdUsesRt, idExMemRead, idExRt, mulStart, branchTaken,
        output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble,
               mulCapture, state, stallCycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use stall, multiply freeze and branch flush sequencing for the 5-stage core.
// State advances on the falling clock edge, in step with the pipeline registers.
module hazard_stall_controller #(
    parameter int MUL_CYCLES      = 4,
    parameter int CNT_WIDTH       = 4,
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic                     clk,
    input logic                     reset,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    state_t                     curState, nextState;
    logic [CNT_WIDTH-1:0]       cnt, cntNext;
    logic [STALL_CNT_WIDTH-1:0] stallCnt;
    logic                       loadUse;
    logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble, mulCapture;

    assign loadUse = bus.idExMemRead && (bus.idExRt != 5'd0) &&
                     ((bus.idExRt == bus.ifIdRs) ||
                      (bus.ifIdUsesRt && (bus.idExRt == bus.ifIdRt)));

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        exMemBubble = 1'b0;
        mulCapture  = 1'b0;
        nextState   = curState;
        cntNext     = cnt;

        case (curState)
            RUN: begin
                if (bus.mulStart) begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    idExWrite   = 1'b0;
                    exMemBubble = 1'b1;
                    cntNext     = CNT_WIDTH'(MUL_CYCLES - 2);
                    // A two-cycle multiply has no wait phase at all
                    nextState   = (MUL_CYCLES == 2) ? MUL_DONE : MUL_WAIT;
                end else if (bus.branchTaken) begin
                    ifIdFlush = 1'b1;
                end else if (loadUse) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end
            end
            MUL_WAIT: begin
                pcWrite     = 1'b0;
                ifIdWrite   = 1'b0;
                idExWrite   = 1'b0;
                exMemBubble = 1'b1;
                cntNext     = cnt - CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(1)) nextState = MUL_DONE;
            end
            MUL_DONE: begin
                // mulStart still flags the finishing multiply, so it is not a new one
                mulCapture = 1'b1;
                nextState  = RUN;
                if (bus.branchTaken) begin
                    ifIdFlush = 1'b1;
                end else if (loadUse) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExBubble = 1'b1;
                end
            end
            default: nextState = RUN;
        endcase

        if (reset) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            idExBubble  = 1'b1;
            exMemBubble = 1'b1;
            ifIdFlush   = 1'b0;
            mulCapture  = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            curState <= RUN;
            cnt      <= '0;
            stallCnt <= '0;
        end else begin
            curState <= nextState;
            cnt      <= cntNext;
            if (!pcWrite && (stallCnt != '1)) stallCnt <= stallCnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign bus.pcWrite     = pcWrite;
    assign bus.ifIdWrite   = ifIdWrite;
    assign bus.ifIdFlush   = ifIdFlush;
    assign bus.idExWrite   = idExWrite;
    assign bus.idExBubble  = idExBubble;
    assign bus.exMemBubble = exMemBubble;
    assign bus.mulCapture  = mulCapture;
    assign bus.state       = curState;
    assign bus.stallCycles = stallCnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: reset, load-use, multiply freeze,
// priority, multiply abort and stall counter saturation.
module tb_hazard_stall_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    hazard_stall_controller_if #(.STALL_CNT_WIDTH(4)) bus ();

    hazard_stall_controller #(
        .MUL_CYCLES(4),
        .CNT_WIDTH(4),
        .STALL_CNT_WIDTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.ifIdRs      = 5'd0;
        bus.ifIdRt      = 5'd0;
        bus.ifIdUsesRt  = 1'b0;
        bus.idExMemRead = 1'b0;
        bus.idExRt      = 5'd0;
        bus.mulStart    = 1'b0;
        bus.branchTaken = 1'b0;
    endtask

    // Called just after a falling edge so the pulse sits well away from the next one
    task automatic resetPulse();
        clearInputs();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.pcWrite !== 1'b0) begin bad++; $display("FAIL rst_pcWrite got=%0b exp=0", bus.pcWrite); end
        total++; if (bus.exMemBubble !== 1'b1) begin bad++; $display("FAIL rst_exMemBubble got=%0b exp=1", bus.exMemBubble); end
        total++; if (bus.idExBubble !== 1'b1) begin bad++; $display("FAIL rst_idExBubble got=%0b exp=1", bus.idExBubble); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        total++; if (bus.stallCycles !== 4'd0) begin bad++; $display("FAIL rst_stallCycles got=%0d exp=0", bus.stallCycles); end
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL rst_release_pcWrite got=%0b exp=1", bus.pcWrite); end
        @(negedge clk); #1;
        total++; if (bus.stallCycles !== 4'd0) begin bad++; $display("FAIL rst_idle_stall got=%0d exp=0", bus.stallCycles); end
    endtask

    task automatic test_load_use();
        resetPulse();
        bus.idExMemRead = 1'b1; bus.idExRt = 5'd5; bus.ifIdRs = 5'd5;
        #1;
        total++; if (bus.pcWrite !== 1'b0) begin bad++; $display("FAIL lu_pcWrite got=%0b exp=0", bus.pcWrite); end
        total++; if (bus.idExBubble !== 1'b1) begin bad++; $display("FAIL lu_idExBubble got=%0b exp=1", bus.idExBubble); end
        total++; if (bus.ifIdWrite !== 1'b0) begin bad++; $display("FAIL lu_ifIdWrite got=%0b exp=0", bus.ifIdWrite); end
        total++; if (bus.idExWrite !== 1'b1) begin bad++; $display("FAIL lu_idExWrite got=%0b exp=1", bus.idExWrite); end
        @(negedge clk); #1;
        total++; if (bus.stallCycles !== 4'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", bus.stallCycles); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL lu_state got=%0d exp=0", bus.state); end
        // Register zero never creates a hazard
        bus.idExRt = 5'd0; bus.ifIdRs = 5'd0;
        #1;
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL lu_r0_pcWrite got=%0b exp=1", bus.pcWrite); end
        total++; if (bus.idExBubble !== 1'b0) begin bad++; $display("FAIL lu_r0_bubble got=%0b exp=0", bus.idExBubble); end
        @(negedge clk); #1;
        total++; if (bus.stallCycles !== 4'd1) begin bad++; $display("FAIL lu_r0_stall got=%0d exp=1", bus.stallCycles); end
        // rt match only counts when the instruction reads rt
        bus.idExRt = 5'd7; bus.ifIdRt = 5'd7; bus.ifIdRs = 5'd3; bus.ifIdUsesRt = 1'b1;
        #1;
        total++; if (bus.pcWrite !== 1'b0) begin bad++; $display("FAIL lu_rt_pcWrite got=%0b exp=0", bus.pcWrite); end
        bus.ifIdUsesRt = 1'b0;
        #1;
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL lu_rt_unused_pcWrite got=%0b exp=1", bus.pcWrite); end
        @(negedge clk); #1;
        clearInputs();
    endtask

    task automatic test_multiply();
        logic [1:0] expSt  [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
        logic       expPc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       expCap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       expMb  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        resetPulse();
        bus.mulStart = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (bus.state !== expSt[i]) begin bad++; $display("FAIL mul_state[%0d] got=%0d exp=%0d", i, bus.state, expSt[i]); end
            total++; if (bus.pcWrite !== expPc[i]) begin bad++; $display("FAIL mul_pcWrite[%0d] got=%0b exp=%0b", i, bus.pcWrite, expPc[i]); end
            total++; if (bus.mulCapture !== expCap[i]) begin bad++; $display("FAIL mul_capture[%0d] got=%0b exp=%0b", i, bus.mulCapture, expCap[i]); end
            total++; if (bus.exMemBubble !== expMb[i]) begin bad++; $display("FAIL mul_exMemBubble[%0d] got=%0b exp=%0b", i, bus.exMemBubble, expMb[i]); end
            @(negedge clk); #1;
        end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL mul_no_restart got=%0d exp=0", bus.state); end
        total++; if (bus.stallCycles !== 4'd3) begin bad++; $display("FAIL mul_stall got=%0d exp=3", bus.stallCycles); end
        bus.mulStart = 1'b0;
        #1;
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL mul_after_pcWrite got=%0b exp=1", bus.pcWrite); end
        @(negedge clk); #1;
    endtask

    task automatic test_priority();
        resetPulse();
        bus.mulStart = 1'b1; bus.branchTaken = 1'b1;
        bus.idExMemRead = 1'b1; bus.idExRt = 5'd5; bus.ifIdRs = 5'd5;
        #1;
        total++; if (bus.ifIdFlush !== 1'b0) begin bad++; $display("FAIL pri_flush got=%0b exp=0", bus.ifIdFlush); end
        total++; if (bus.exMemBubble !== 1'b1) begin bad++; $display("FAIL pri_exMemBubble got=%0b exp=1", bus.exMemBubble); end
        total++; if (bus.idExBubble !== 1'b0) begin bad++; $display("FAIL pri_idExBubble got=%0b exp=0", bus.idExBubble); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (i < 2) begin
                total++; if (bus.ifIdFlush !== 1'b0) begin bad++; $display("FAIL pri_wait_flush[%0d] got=%0b exp=0", i, bus.ifIdFlush); end
            end
        end
        // Now in MUL_DONE: held branch is honoured, load-use is not
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL pri_done_state got=%0d exp=2", bus.state); end
        total++; if (bus.ifIdFlush !== 1'b1) begin bad++; $display("FAIL pri_done_flush got=%0b exp=1", bus.ifIdFlush); end
        total++; if (bus.mulCapture !== 1'b1) begin bad++; $display("FAIL pri_done_capture got=%0b exp=1", bus.mulCapture); end
        total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL pri_done_pcWrite got=%0b exp=1", bus.pcWrite); end
        @(negedge clk); #1;
        clearInputs();
        #1;
        total++; if (bus.ifIdFlush !== 1'b0) begin bad++; $display("FAIL pri_after_flush got=%0b exp=0", bus.ifIdFlush); end
        @(negedge clk); #1;
    endtask

    task automatic test_abort();
        resetPulse();
        bus.mulStart = 1'b1;
        @(negedge clk); #1;
        bus.mulStart = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL abort_pre_state got=%0d exp=1", bus.state); end
        reset = 1'b1;
        #1;
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", bus.state); end
        total++; if (bus.pcWrite !== 1'b0) begin bad++; $display("FAIL abort_rst_pcWrite got=%0b exp=0", bus.pcWrite); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.pcWrite !== 1'b1) begin bad++; $display("FAIL abort_pcWrite[%0d] got=%0b exp=1", i, bus.pcWrite); end
            total++; if (bus.mulCapture !== 1'b0) begin bad++; $display("FAIL abort_capture[%0d] got=%0b exp=0", i, bus.mulCapture); end
            total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL abort_state[%0d] got=%0d exp=0", i, bus.state); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        resetPulse();
        bus.idExMemRead = 1'b1; bus.idExRt = 5'd9; bus.ifIdRs = 5'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            exp = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            total++; if (bus.stallCycles !== exp) begin bad++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", i, bus.stallCycles, exp); end
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multiply();
        test_priority();
        test_abort();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
